// File: rtl/task_11_pkg.sv
// Shared types and default sizes for the task 11 packet sequencer.
package task_11_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DISCARD,
        RUN,
        SEND
    } ctrl_state_t;

    localparam int CTRL_BYTE_CNT_W      = 12;
    localparam int TASK_11_NUM_BYTES_IN = 512;
    localparam int TASK_11_NUM_RESULTS  = 8;

    // States in which the task manager may push input bytes.
    function automatic logic accepts_input(ctrl_state_t s);
        return (s == IDLE) || (s == LOAD) || (s == DISCARD);
    endfunction

endpackage

// File: rtl/task_11_ctrl_wdog.sv
// Watchdog for the RUN/SEND phases: counts enabled cycles, flags the last one before the limit.
module task_11_ctrl_wdog #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int            CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Expiry is seen in the cycle that completes the budget so the reaction lands exactly on it.
    assign o_expire = i_en && (cnt_q == LIMIT_M1);

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en && !o_expire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/task_11_ctrl.sv
// Packet sequencer: load input packet, start replay, collect results, hand off to task manager.
// Optional watchdog on RUN/SEND enabled by defining TASK_11_CTRL_TIMEOUT_EN.
module task_11_ctrl
    import task_11_pkg::*;
#(
    parameter int NUM_BYTES_IN = TASK_11_NUM_BYTES_IN,
    parameter int NUM_RESULTS  = TASK_11_NUM_RESULTS
`ifdef TASK_11_CTRL_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_tdata_valid,
    input  logic                           i_tdata_last,
    output logic                           o_tready,
    output logic                           o_load_en,
    output logic [CTRL_BYTE_CNT_W-1:0]     o_byte_cnt,
    output logic                           o_replay_start,
    input  logic                           i_result_valid,
    output logic                           o_result_we,
    output logic [$clog2(NUM_RESULTS)-1:0] o_result_idx,
    input  logic                           i_tmanager_ready,
    output logic                           o_send_start,
    input  logic                           i_out_last,
    output logic                           o_busy,
    output logic                           o_err,
    output logic                           o_timeout
);

    localparam int CNT_W = $clog2(NUM_RESULTS) + 1;

    localparam logic [CTRL_BYTE_CNT_W-1:0] BYTES    = CTRL_BYTE_CNT_W'(NUM_BYTES_IN);
    localparam logic [CTRL_BYTE_CNT_W-1:0] BYTES_M1 = CTRL_BYTE_CNT_W'(NUM_BYTES_IN - 1);
    localparam logic [CNT_W-1:0]           RES      = CNT_W'(NUM_RESULTS);
    localparam logic [CNT_W-1:0]           RES_M1   = CNT_W'(NUM_RESULTS - 1);

    ctrl_state_t                state_q, state_d;
    logic [CTRL_BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0]           result_cnt_q, result_cnt_d;
    logic                       err_q, err_d;
    logic                       sent_q, sent_d;
    logic                       send_start_q, send_start_d;
    logic                       tready_q, busy_q, replay_q;
    logic                       load_en, result_we;

`ifdef TASK_11_CTRL_TIMEOUT_EN
    logic wd_expire;
    logic timeout_q, timeout_d;

    task_11_ctrl_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (state_d != state_q),
        .i_en     ((state_q == RUN) || (state_q == SEND)),
        .o_expire (wd_expire)
    );
`endif

    // NOTE: always_comb uses blocking '=' with every output defaulted first, so no latch can form.
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        result_cnt_d = result_cnt_q;
        err_d        = err_q;
        sent_d       = sent_q;
        load_en      = 1'b0;
        result_we    = 1'b0;
`ifdef TASK_11_CTRL_TIMEOUT_EN
        timeout_d    = 1'b0;
`endif

        case (state_q)
            IDLE, LOAD: begin
                if (i_tdata_valid) begin
                    if (state_q == IDLE) begin
                        err_d = 1'b0;
                    end
                    if (byte_cnt_q < BYTES) begin
                        load_en    = 1'b1;
                        byte_cnt_d = byte_cnt_q + CTRL_BYTE_CNT_W'(1);
                    end
                    if (i_tdata_last) begin
                        if (byte_cnt_q == BYTES_M1) begin
                            state_d = RUN;
                        end else begin
                            err_d      = 1'b1;
                            state_d    = IDLE;
                            byte_cnt_d = '0;
                        end
                    end else if (byte_cnt_q == BYTES) begin
                        err_d   = 1'b1;
                        state_d = DISCARD;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end

            DISCARD: begin
                if (i_tdata_valid && i_tdata_last) begin
                    state_d    = IDLE;
                    byte_cnt_d = '0;
                end
            end

            RUN: begin
                if (i_result_valid && (result_cnt_q < RES)) begin
                    result_we    = 1'b1;
                    result_cnt_d = result_cnt_q + CNT_W'(1);
                    if (result_cnt_q == RES_M1) begin
                        state_d = SEND;
                    end
                end
            end

            SEND: begin
                // Completion is only meaningful once transmission has been started.
                if (sent_q && i_out_last) begin
                    state_d      = IDLE;
                    byte_cnt_d   = '0;
                    result_cnt_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef TASK_11_CTRL_TIMEOUT_EN
        // Any legitimate state change in the expiry cycle takes priority over the timeout.
        if (wd_expire && (state_d == state_q)) begin
            state_d      = IDLE;
            err_d        = 1'b1;
            timeout_d    = 1'b1;
            byte_cnt_d   = '0;
            result_cnt_d = '0;
        end
`endif

        if (state_d != SEND) begin
            sent_d = 1'b0;
        end
        send_start_d = (state_d == SEND) && !sent_q && i_tmanager_ready;
        sent_d       = sent_d | send_start_d;
    end

    // NOTE: registers use a non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            byte_cnt_q   <= '0;
            result_cnt_q <= '0;
            err_q        <= 1'b0;
            sent_q       <= 1'b0;
            send_start_q <= 1'b0;
            tready_q     <= 1'b1;
            busy_q       <= 1'b0;
            replay_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            result_cnt_q <= result_cnt_d;
            err_q        <= err_d;
            sent_q       <= sent_d;
            send_start_q <= send_start_d;
            tready_q     <= accepts_input(state_d);
            busy_q       <= (state_d != IDLE);
            replay_q     <= (state_d == RUN) && (state_q != RUN);
        end
    end

`ifdef TASK_11_CTRL_TIMEOUT_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end
    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    // The write strobe is combinational, so it is masked while reset holds the buffer idle.
    assign o_load_en      = load_en && !i_rst;
    assign o_result_we    = result_we;
    assign o_byte_cnt     = byte_cnt_q;
    assign o_result_idx   = result_cnt_q[CNT_W-2:0];
    assign o_tready       = tready_q;
    assign o_busy         = busy_q;
    assign o_replay_start = replay_q;
    assign o_send_start   = send_start_q;
    assign o_err          = err_q;

endmodule

// File: tb/tb_task_11_ctrl.sv
// Directed bench for task_11_ctrl: nominal, short, long, excess-result, watchdog and mid-packet reset.
module tb_task_11_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tdata_valid = 1'b0;
    logic        tdata_last = 1'b0;
    logic        result_valid = 1'b0;
    logic        tmanager_ready = 1'b0;
    logic        out_last = 1'b0;
    logic        tready, load_en, replay_start, result_we, send_start, busy, err, timeout;
    logic [11:0] byte_cnt;
    logic [2:0]  result_idx;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    task_11_ctrl #(
        .NUM_BYTES_IN (512),
        .NUM_RESULTS  (8)
`ifdef TASK_11_CTRL_TIMEOUT_EN
        , .TIMEOUT_CYCLES (100)
`endif
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_tdata_valid    (tdata_valid),
        .i_tdata_last     (tdata_last),
        .o_tready         (tready),
        .o_load_en        (load_en),
        .o_byte_cnt       (byte_cnt),
        .o_replay_start   (replay_start),
        .i_result_valid   (result_valid),
        .o_result_we      (result_we),
        .o_result_idx     (result_idx),
        .i_tmanager_ready (tmanager_ready),
        .o_send_start     (send_start),
        .i_out_last       (out_last),
        .o_busy           (busy),
        .o_err            (err),
        .o_timeout        (timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Bytes numbered first..last_byte, one per cycle; sampled at the following negedge.
    task automatic drive_bytes(input int first, input int last_byte, input int last_at, inout int loads);
        for (int i = first; i <= last_byte; i++) begin
            @(posedge clk); #1;
            tdata_valid = 1'b1;
            tdata_last  = (i == last_at);
            @(negedge clk);
            loads += int'(load_en);
        end
    endtask

    task automatic idle_step();
        @(posedge clk); #1;
        tdata_valid  = 1'b0;
        tdata_last   = 1'b0;
        result_valid = 1'b0;
        out_last     = 1'b0;
        @(negedge clk);
    endtask

    task automatic drive_results(input int n, input int first_idx, inout int wes);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            result_valid = 1'b1;
            @(negedge clk);
            if (first_idx + i < 8) check("result_idx", 32'(result_idx), 32'(first_idx + i));
            wes += int'(result_we);
        end
    endtask

    task automatic out_last_to_idle();
        @(posedge clk); #1;
        result_valid = 1'b0;
        out_last     = 1'b1;
        @(negedge clk);
        idle_step();
        check("idle_tready", 32'(tready), 1);
        check("idle_busy", 32'(busy), 0);
        check("idle_byte_cnt", 32'(byte_cnt), 0);
    endtask

    initial begin
        int loads, wes, starts, pulses, first_k;

        // Reset state
        #2 rst = 1'b1;
        #3;
        check("rst_tready", 32'(tready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_byte_cnt", 32'(byte_cnt), 0);
        check("rst_idx", 32'(result_idx), 0);
        check("rst_err", 32'(err), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_replay", 32'(replay_start), 0);
        check("rst_send", 32'(send_start), 0);
        @(negedge clk) rst = 1'b0;

        // Nominal packet
        loads = 0;
        drive_bytes(1, 512, 512, loads);
        idle_step();
        check("nom_loads", 32'(loads), 512);
        check("nom_replay_n1", 32'(replay_start), 1);
        check("nom_tready_run", 32'(tready), 0);
        check("nom_busy_run", 32'(busy), 1);
        check("nom_byte_cnt", 32'(byte_cnt), 512);
        idle_step();
        check("nom_replay_once", 32'(replay_start), 0);
        tmanager_ready = 1'b1;
        wes = 0;
        drive_results(8, 0, wes);
        check("nom_result_we", 32'(wes), 8);
        idle_step();
        check("nom_send_m1", 32'(send_start), 1);
        check("nom_tready_send", 32'(tready), 0);
        idle_step();
        check("nom_send_once", 32'(send_start), 0);
        out_last_to_idle();
        check("nom_err", 32'(err), 0);

        // Short packet
        loads = 0;
        drive_bytes(1, 300, 300, loads);
        idle_step();
        check("short_loads", 32'(loads), 300);
        check("short_err", 32'(err), 1);
        check("short_busy", 32'(busy), 0);
        check("short_replay", 32'(replay_start), 0);

        // Long packet, whose first byte clears the sticky error
        loads = 0;
        drive_bytes(1, 2, 0, loads);
        check("long_err_cleared", 32'(err), 0);
        drive_bytes(3, 516, 0, loads);
        check("long_discard_err", 32'(err), 1);
        check("long_discard_busy", 32'(busy), 1);
        check("long_discard_tready", 32'(tready), 1);
        check("long_discard_cnt", 32'(byte_cnt), 512);
        drive_bytes(517, 520, 520, loads);
        idle_step();
        check("long_loads", 32'(loads), 512);
        check("long_busy", 32'(busy), 0);
        check("long_err_after", 32'(err), 1);

        // Excess results and delayed manager ready
        tmanager_ready = 1'b0;
        loads = 0;
        drive_bytes(1, 512, 512, loads);
        idle_step();
        check("exc_replay", 32'(replay_start), 1);
        check("exc_err", 32'(err), 0);
        wes = 0;
        drive_results(10, 0, wes);
        check("exc_result_we", 32'(wes), 8);
        check("exc_busy_send", 32'(busy), 1);
        check("exc_tready_send", 32'(tready), 0);
        starts = int'(send_start);
        for (int i = 0; i < 18; i++) begin
            idle_step();
            starts += int'(send_start);
        end
        check("exc_no_send_while_unready", 32'(starts), 0);
        @(posedge clk); #1;
        tmanager_ready = 1'b1;
        @(negedge clk);
        check("exc_send_not_yet", 32'(send_start), 0);
        @(posedge clk); #1;
        out_last = 1'b1;
        @(negedge clk);
        check("exc_send_after_ready", 32'(send_start), 1);
        idle_step();
        check("exc_send_once", 32'(send_start), 0);
        check("exc_idle_same_cycle_last", 32'(busy), 0);
        check("exc_tready", 32'(tready), 1);

        // Watchdog: only three results arrive
        loads = 0;
        drive_bytes(1, 512, 512, loads);
        idle_step();
        check("to_replay", 32'(replay_start), 1);
        pulses = 0;
        first_k = 0;
        for (int k = 1; k <= 150; k++) begin
            @(posedge clk); #1;
            result_valid = (k <= 3);
            @(negedge clk);
            if (timeout) begin
                pulses++;
                if (first_k == 0) first_k = k;
            end
        end
`ifdef TASK_11_CTRL_TIMEOUT_EN
        check("to_pulses", 32'(pulses), 1);
        check("to_cycle", 32'(first_k), 100);
        check("to_err", 32'(err), 1);
        check("to_busy", 32'(busy), 0);
        check("to_byte_cnt", 32'(byte_cnt), 0);
        check("to_idx", 32'(result_idx), 0);
`else
        check("to_pulses", 32'(pulses), 0);
        check("to_stuck_busy", 32'(busy), 1);
        check("to_stuck_tready", 32'(tready), 0);
        check("to_stuck_idx", 32'(result_idx), 3);
        wes = 0;
        drive_results(5, 3, wes);
        check("to_rest_we", 32'(wes), 5);
        idle_step();
        check("to_send", 32'(send_start), 1);
        out_last_to_idle();
`endif

        // Asynchronous reset mid-load, then a fresh packet
        loads = 0;
        drive_bytes(1, 200, 0, loads);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_byte_cnt", 32'(byte_cnt), 0);
        check("mid_rst_tready", 32'(tready), 1);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_load_en", 32'(load_en), 0);
        check("mid_rst_err", 32'(err), 0);
        tdata_valid = 1'b0;
        tdata_last  = 1'b0;
        @(negedge clk) rst = 1'b0;
        loads = 0;
        drive_bytes(1, 512, 512, loads);
        idle_step();
        check("post_rst_loads", 32'(loads), 512);
        check("post_rst_replay", 32'(replay_start), 1);
        wes = 0;
        drive_results(8, 0, wes);
        check("post_rst_we", 32'(wes), 8);
        idle_step();
        check("post_rst_send", 32'(send_start), 1);
        out_last_to_idle();
        check("post_rst_err", 32'(err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
